// File: rtl/mda_hdmi_ctrl.sv
// rtl/mda_hdmi_ctrl.sv - MDA frame-lock controller driving HDMI palette select and output enable
// Debounces the colour switches, measures lines per frame and gates video on a stable lock.
module mda_hdmi_ctrl #(
  parameter int DEBOUNCE_MAX  = 16384,
  parameter int LINES_NOMINAL = 370,
  parameter int LINE_TOL      = 4,
  parameter int LOCK_FRAMES   = 4,
  parameter int VS_TIMEOUT    = 1048576
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       switch2,
  input  logic       switch3,
  output logic [1:0] palette,
  output logic       palette_chg,
  output logic       locked,
  output logic       out_enable,
  output logic [9:0] frame_lines
);

  localparam int DW = $clog2(DEBOUNCE_MAX);
  localparam int WW = $clog2(VS_TIMEOUT);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MAX - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(VS_TIMEOUT - 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);
  localparam logic [9:0]    LINE_MAX  = 10'h3FF;
  localparam logic [9:0]    LINES_LO  = 10'(LINES_NOMINAL - LINE_TOL);
  localparam logic [9:0]    LINES_HI  = 10'(LINES_NOMINAL + LINE_TOL);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   good_cnt, good_nxt;
  logic            miss_cnt, miss_nxt;

  logic [1:0]      sw_s1, sw_s2, stable;
  logic [DW-1:0]   db_cnt [2];
  logic            hs_prev, vs_prev;
  logic            hs_rise, vs_rise;
  logic [9:0]      line_cnt, cand;
  logic            good;
  logic [WW-1:0]   wd;
  logic            timeout;

  assign hs_rise = hsync & ~hs_prev;
  assign vs_rise = vsync & ~vs_prev;
  assign timeout = ~vs_rise && (wd == WD_LAST);

  // Bit 1 is switch2 and bit 0 is switch3, so stable lines up with the palette encoding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      stable    <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sw_s1 <= {switch2, switch3};
      sw_s2 <= sw_s1;
      for (int i = 0; i < 2; i++) begin
        if (sw_s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sw_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  // A line starting in the vsync cycle still belongs to the frame being closed.
  always_comb begin
    cand = line_cnt;
    if (hs_rise && line_cnt != LINE_MAX) cand = line_cnt + 10'd1;
  end

  assign good = (cand >= LINES_LO) && (cand <= LINES_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev     <= 1'b0;
      vs_prev     <= 1'b0;
      line_cnt    <= '0;
      frame_lines <= '0;
      palette     <= '0;
      palette_chg <= 1'b0;
      wd          <= '0;
    end else begin
      hs_prev     <= hsync;
      vs_prev     <= vsync;
      palette_chg <= vs_rise && (stable != palette);
      if (vs_rise) begin
        line_cnt    <= '0;
        frame_lines <= cand;
        palette     <= stable;
        wd          <= '0;
      end else begin
        if (hs_rise && line_cnt != LINE_MAX) line_cnt <= line_cnt + 10'd1;
        if (wd != WD_LAST) wd <= wd + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      miss_cnt   <= 1'b0;
      locked     <= 1'b0;
      out_enable <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      miss_cnt   <= miss_nxt;
      locked     <= (state_nxt == LOCKED);
      out_enable <= (state_nxt == LOCKED);
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    miss_nxt  = miss_cnt;
    if (timeout) begin
      state_nxt = SEARCH;
      good_nxt  = '0;
      miss_nxt  = 1'b0;
    end else if (vs_rise) begin
      case (state)
        SEARCH: begin
          if (good) begin
            if (LOCK_FRAMES == 1) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
            end else begin
              state_nxt = CHECK;
              good_nxt  = GW'(1);
            end
            miss_nxt = 1'b0;
          end
        end
        CHECK: begin
          if (!good) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
          end else if (good_cnt == GOOD_LAST) begin
            state_nxt = LOCKED;
            good_nxt  = '0;
            miss_nxt  = 1'b0;
          end else begin
            good_nxt = good_cnt + GW'(1);
          end
        end
        LOCKED: begin
          if (good) begin
            miss_nxt = 1'b0;
          end else if (miss_cnt) begin
            state_nxt = SEARCH;
            good_nxt  = '0;
            miss_nxt  = 1'b0;
          end else begin
            miss_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = SEARCH;
          good_nxt  = '0;
          miss_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
